// File: rtl/seven_segment_scanner_if.sv
// Bus bundle for seven_segment_scanner.
//
// The master side supplies new display contents with a single-cycle load strobe.
// The slave side (the scanner) acknowledges a commit and drives the display lines.
//   digitsIn   [15:0] four hex digits, [3:0] = rightmost digit
//   dpIn       [3:0]  decimal points, active-high, bit i = digit i
//   load              capture strobe for digitsIn/dpIn
//   loadAck           one-cycle pulse when a loaded value reaches the display
//   anodes     [3:0]  one-hot active-low digit enables
//   segments   [6:0]  active-low segments, bit0 = a ... bit6 = g
//   dp                active-low decimal point of the lit digit
//   frameStart        one-cycle pulse when digit 0 of a new frame is first shown
interface seven_segment_scanner_if;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn;
  logic        load;
  logic        loadAck;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frameStart;

  modport master (
    output digitsIn,
    output dpIn,
    output load,
    input  loadAck,
    input  anodes,
    input  segments,
    input  dp,
    input  frameStart
  );

  modport slave (
    input  digitsIn,
    input  dpIn,
    input  load,
    output loadAck,
    output anodes,
    output segments,
    output dp,
    output frameStart
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed driver for a common-anode seven-segment display.
//
// A prescaler produces a refresh tick every REFRESH_DIV cycles; each tick advances a 2-bit
// digit index. Loaded values wait in a pending register and are only committed to the
// display register on the tick that wraps the index 3 -> 0, so a frame never mixes digits
// from two loads. All display outputs are registered (one cycle behind index/display).
//
// Ports:
//   clock   system clock, rising edge
//   resetN  synchronous active-low reset
//   bus     seven_segment_scanner_if.slave (load/ack handshake and display lines)
//
// Parameters:
//   REFRESH_DIV  cycles each digit is lit, 2 .. 2**DIV_WIDTH
//   DIV_WIDTH    prescaler width
//
// Optional build macro:
//   SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN  blank leading zero digits 3..1 (segments off,
//                                        anode and dp unaffected); digit 0 never blanked.
module seven_segment_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_WIDTH   = 17
) (
  input logic                    clock,
  input logic                    resetN,
  seven_segment_scanner_if.slave bus
);

  if (REFRESH_DIV < 2) begin : g_div_too_small
    $error("seven_segment_scanner: REFRESH_DIV must be at least 2");
  end
  if (64'(REFRESH_DIV) > (64'd1 << DIV_WIDTH)) begin : g_div_too_large
    $error("seven_segment_scanner: REFRESH_DIV does not fit in DIV_WIDTH bits");
  end

  localparam logic [DIV_WIDTH-1:0] DivMax = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // State. Display and pending words are packed as {dp[3:0], digits[15:0]}.
  logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [1:0]           index_q, index_d;
  logic [19:0]          display_q, display_d;
  logic [19:0]          pending_q, pending_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 commit_q, commit_d;

  // Registered outputs.
  logic [3:0]           anodes_q, anodes_d;
  logic [6:0]           segments_q, segments_d;
  logic                 dp_q, dp_d;
  logic                 load_ack_q, load_ack_d;
  logic                 frame_start_q, frame_start_d;

  logic                 tick;
  logic                 commit;
  logic [19:0]          load_word;
  logic [3:0]           cur_nibble;
  logic [3:0]           dp_bits;
  logic                 blank;

  assign tick      = (prescaler_q == DivMax);
  assign commit    = tick && (index_q == 2'd3);
  assign load_word = {bus.dpIn, bus.digitsIn};

  // Prescaler and digit index.
  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + DivOne;
    index_d     = tick ? index_q + 2'd1 : index_q;
  end

  // Pending/display handshake. A load in the commit cycle bypasses the pending register.
  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    display_d       = display_q;
    load_ack_d      = 1'b0;
    commit_d        = commit;

    if (bus.load) begin
      pending_d = load_word;
    end

    if (commit) begin
      if (bus.load) begin
        display_d  = load_word;
        load_ack_d = 1'b1;
      end else if (pending_valid_q) begin
        display_d  = pending_q;
        load_ack_d = 1'b1;
      end
      pending_valid_d = 1'b0;
    end else if (bus.load) begin
      pending_valid_d = 1'b1;
    end
  end

  assign cur_nibble = display_q[{index_q, 2'b00} +: 4];
  assign dp_bits    = display_q[19:16];

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    blank = 1'b0;
    case (index_q)
      2'd3:    blank = (display_q[15:12] == 4'h0);
      2'd2:    blank = (display_q[15:8] == 8'h00);
      2'd1:    blank = (display_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Output decode from the current index/display; registered below.
  always_comb begin
    anodes_d      = ~(4'b0001 << index_q);
    segments_d    = blank ? 7'h7F : hex_to_seg(cur_nibble);
    dp_d          = ~dp_bits[index_q];
    // commit_q marks the cycle index sits at 0 after a wrap; its outputs land one cycle later.
    frame_start_d = commit_q;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      prescaler_q     <= '0;
      index_q         <= 2'd0;
      display_q       <= 20'h0_0000;
      pending_q       <= 20'h0_0000;
      pending_valid_q <= 1'b0;
      commit_q        <= 1'b0;
      anodes_q        <= 4'b1111;
      segments_q      <= 7'h7F;
      dp_q            <= 1'b1;
      load_ack_q      <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      prescaler_q     <= prescaler_d;
      index_q         <= index_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      commit_q        <= commit_d;
      anodes_q        <= anodes_d;
      segments_q      <= segments_d;
      dp_q            <= dp_d;
      load_ack_q      <= load_ack_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign bus.anodes     = anodes_q;
  assign bus.segments   = segments_q;
  assign bus.dp         = dp_q;
  assign bus.loadAck    = load_ack_q;
  assign bus.frameStart = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with REFRESH_DIV = 4 (16-cycle frames).
// cyc counts rising edges since the last reset release; with this divider the commit
// tick lands on edges 16, 32, 48, ... and the new frame is shown from the following edge.
module tb_seven_segment_scanner;

  logic clock;
  logic resetN;
  int   n_vec;
  int   n_err;
  int   cyc;

  seven_segment_scanner_if bus_if ();

  seven_segment_scanner #(
    .REFRESH_DIV(4),
    .DIV_WIDTH  (17)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    check("rst_anodes", 16'(bus_if.anodes), 16'hF);
    check("rst_segments", 16'(bus_if.segments), 16'h7F);
    check("rst_dp", 16'(bus_if.dp), 16'h1);
    check("rst_loadAck", 16'(bus_if.loadAck), 16'h0);
    check("rst_frameStart", 16'(bus_if.frameStart), 16'h0);
  endtask

  // Step to edge number target; loadAck must be low before it and equal ack_exp at it.
  task automatic run_to(input int target, input logic ack_exp);
    logic exp_ack;
    while (cyc < target) begin
      step();
      exp_ack = (cyc == target) ? ack_exp : 1'b0;
      check("loadAck", 16'(bus_if.loadAck), 16'(exp_ack));
    end
  endtask

  // Checks the 16 edges of one frame: digit order, segments, dp, frameStart, no loadAck.
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] dpv, input logic fs_first);
    logic [6:0] segs[4];
    logic [3:0] an_exp;
    logic       dp_exp;
    logic       fs_exp;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        an_exp = ~(4'b0001 << d);
        dp_exp = ~dpv[d];
        fs_exp = (d == 0 && c == 0) ? fs_first : 1'b0;
        check("anodes", 16'(bus_if.anodes), 16'(an_exp));
        check("segments", 16'(bus_if.segments), 16'(segs[d]));
        check("dp", 16'(bus_if.dp), 16'(dp_exp));
        check("frameStart", 16'(bus_if.frameStart), 16'(fs_exp));
        check("loadAck", 16'(bus_if.loadAck), 16'h0);
      end
    end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    cyc             = 0;
    resetN          = 1'b0;
    bus_if.load     = 1'b0;
    bus_if.digitsIn = 16'h0000;
    bus_if.dpIn     = 4'b0000;

    // 1. Reset for 3 cycles, then free-running scan of an all-zero display.
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs();
    end
    resetN = 1'b1;
    cyc    = 0;
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b0);
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);

    // 2. Load 1234 / dp on digit 2 while index = 1; commit at edge 48.
    run_to(36, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.digitsIn = 16'h1234;
    bus_if.dpIn     = 4'b0100;
    step();
    bus_if.load = 1'b0;
    bus_if.dpIn = 4'b0000;
    check("ack_at_load", 16'(bus_if.loadAck), 16'h0);
    run_to(47, 1'b0);
    check("old_seg_before_wrap", 16'(bus_if.segments), 16'h40);
    run_to(48, 1'b1);
    run_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0100, 1'b1);

    // 3. Back-to-back loads, last one wins, single ack at edge 80.
    run_to(65, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.digitsIn = 16'hAAAA;
    step();
    bus_if.load = 1'b0;
    check("ack_first_load", 16'(bus_if.loadAck), 16'h0);
    run_to(67, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.digitsIn = 16'hBEEF;
    step();
    bus_if.load = 1'b0;
    check("ack_second_load", 16'(bus_if.loadAck), 16'h0);
    run_to(80, 1'b1);
    run_frame(7'h0E, 7'h06, 7'h06, 7'h03, 4'b0000, 1'b1);

    // 4. Load in the exact commit cycle (state after edge 111) bypasses pending.
    run_to(111, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.digitsIn = 16'h00C5;
    step();
    bus_if.load = 1'b0;
    check("ack_bypass", 16'(bus_if.loadAck), 16'h1);
    // Next commit (edge 128) must not ack again: checked inside run_frame.
    run_frame(7'h12, 7'h46, 7'h40, 7'h40, 4'b0000, 1'b1);

    // 5. Reset mid-frame discards a pending load.
    run_to(129, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.digitsIn = 16'h9999;
    bus_if.dpIn     = 4'b1111;
    step();
    bus_if.load = 1'b0;
    bus_if.dpIn = 4'b0000;
    run_to(135, 1'b0);
    resetN = 1'b0;
    step();
    check_reset_outputs();
    step();
    check_reset_outputs();
    resetN = 1'b1;
    cyc    = 0;
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b0);
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);

    // 6. Leading-zero display 0070.
    run_to(33, 1'b0);
    bus_if.load     = 1'b1;
    bus_if.digitsIn = 16'h0070;
    step();
    bus_if.load = 1'b0;
    run_to(48, 1'b1);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    run_frame(7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0000, 1'b1);
`else
    run_frame(7'h40, 7'h78, 7'h40, 7'h40, 4'b0000, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
